sccb_master: RTL and testbench
==============================

Name: sccb_master

Overview:
- Serial Camera Control Bus (SCCB) 3-phase write transmitter for the OV7670.
- Sits directly downstream of the camera configuration sequencer. It accepts one register address/data pair per handshake and serialises device ID, register address and data onto SIO_C/SIO_D.
- Reports bus availability on sccb_ready and flags a non-acknowledged byte on sccb_nack.

Parameters:
- DEVICE_ID, 8'h42: SCCB write ID, sent as phase 1.
- QUARTER, 63: clk_25M cycles per quarter SIO_C period (≈99 kHz SCL).
- BUS_FREE_Q, 8: quarters of idle bus enforced after stop before sccb_ready re-asserts.

Ports:
- clk_25M  in  1  system clock, 25 MHz
- rst  in  1  asynchronous, active-high reset
- sccb_start  in  1  request; may be held high continuously by the sequencer
- sccb_address  in  8  register address, captured on accept
- sccb_data  in  8  register data, captured on accept
- siod_in  in  1  sampled SIO_D pad value
- sccb_ready  out  1  idle, able to accept
- sccb_nack  out  1  ≥1 byte of the last transaction sampled SIO_D=1 in its 9th bit
- sioc  out  1  SIO_C (push-pull)
- siod_out  out  1  SIO_D drive value
- siod_oe  out  1  SIO_D output enable (0 = released/high-Z)

Behaviour:
- Reset (async, immediate), including mid-transaction with no stop generated:
  - Outputs: sioc=1, siod_out=1, siod_oe=1, sccb_ready=1, sccb_nack=0.
  - State: state=IDLE, ready-age counter=0.
- Accept rule:
  - Accept when in IDLE, sccb_start=1 and sccb_ready has been high on at least the two preceding clock edges. This is the second rising edge after ready rises, or any later edge.
  - The delay lets the sequencer load new address/data on the first edge, so a held sccb_start never retransmits stale values.
- On accept:
  - Capture {DEVICE_ID, sccb_address, sccb_data} into a 27-bit shift frame, 9th bit of each byte = release.
  - Clear sccb_nack, zero the quarter counter.
  - sccb_ready=0 from the next cycle.
  - sccb_start while busy is ignored.
- Quarter tick: counter counts 0..QUARTER-1; state and pins advance on wrap. All outputs are registered.
- States:
  - IDLE: sioc=1, siod=1 (oe=1).
  - START_A, 1 quarter: siod=0, sioc=1.
  - START_B, 1 quarter: sioc=0.
  - BIT, 27 bits × 4 quarters:
    - Q0 sioc=0, present bit MSB-first (data changes only while sioc=0).
    - Q1 sioc=0.
    - Q2, Q3 sioc=1.
    - Bits 9, 18, 27 (don't-care): siod_oe=0. siod_in is sampled at the end of Q2; if 1, set sccb_nack (sticky until next accept).
  - STOP_A, 1 quarter: sioc=0, siod=0, oe=1.
  - STOP_B, 1 quarter: sioc=1, siod=0.
  - BUS_FREE, BUS_FREE_Q quarters: siod=1, sioc=1.
  - Then → IDLE with sccb_ready=1.
- Timing:
  - sccb_ready low for exactly (112+BUS_FREE_Q)×QUARTER cycles: 120×63 = 7560 cycles at defaults.
  - sioc high time = 2×QUARTER cycles, sioc low time = 2×QUARTER cycles.
- Bus invariants:
  - siod never changes while sioc=1, except in START_A (fall) and BUS_FREE entry (rise).
- Width rules:
  - Bit index 0..26, 5-bit counter; no wrap beyond 26.
  - Quarter counter sized as ceil(log2(QUARTER)) bits.
- Acknowledge policy: nack is informational only; the transaction always completes all 3 phases.

Test Plan:
- Reset release with sccb_start=1, addr=8'h12, data=8'h80 → accept on 2nd edge after reset deassert.
  - Serial stream 0x42, 0x12, 0x80 MSB-first with 3 released 9th bits.
  - sccb_ready low exactly 7560 cycles.
- Sequencer-style held start: sccb_start stays 1; addr/data change to 8'h11/8'h01 on the first cycle ready is high → the second transaction carries 0x11/0x01, never a repeat of 0x12/0x80.
- siod_in tied 0 → sccb_nack=0. siod_in=1 only during the 2nd 9th bit → sccb_nack=1 at ready, cleared on the next accept.
- Bus monitor over 20 random transactions:
  - Start = siod falling while sioc=1; stop = siod rising while sioc=1.
  - No other siod edges while sioc high.
  - sioc high/low each 126 cycles.
- Assert rst for 1 cycle mid-BIT of phase 2 → same cycle sioc=1, siod_out=1, siod_oe=1, sccb_ready=1, sccb_nack=0. The next request transmits a full, correct frame.
- QUARTER=4, BUS_FREE_Q=2 → ready low 456 cycles; sccb_start pulsed while busy is ignored (no second frame).

Source files
------------

// File: rtl/sccb_master.sv
// SCCB 3-phase write master for the OV7670: serialises device ID, register
// address and data onto SIO_C/SIO_D, one address/data pair per handshake.
module sccb_master #(
    parameter logic [7:0] DEVICE_ID  = 8'h42,
    parameter int          QUARTER    = 63,
    parameter int          BUS_FREE_Q = 8
) (
    input  logic       clk_25M,
    input  logic       rst,
    input  logic       sccb_start,
    input  logic [7:0] sccb_address,
    input  logic [7:0] sccb_data,
    input  logic       siod_in,
    output logic       sccb_ready,
    output logic       sccb_nack,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe
);
    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int FW = (BUS_FREE_Q > 1) ? $clog2(BUS_FREE_Q) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BUS_FREE_Q - 1);

    typedef enum logic [2:0] {
        IDLE, START_A, START_B, BIT, STOP_A, STOP_B, BUS_FREE
    } state_t;

    state_t          r_state;
    logic [QW-1:0]   r_qcnt;
    logic [4:0]      r_bitIdx;
    logic [1:0]      r_phase;
    logic [FW-1:0]   r_freeCnt;
    logic [26:0]     r_frame;
    logic            r_readyAge;
    logic            r_ready;
    logic            r_nack;
    logic            r_sioc;
    logic            r_siod;
    logic            r_oe;
    logic            w_tick;
    logic            w_accept;

    // The 9th bit of every byte is released so the slave may drive it.
    function automatic logic isRelease(input logic [4:0] idx);
        return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
    endfunction

    assign w_tick   = (r_qcnt == Q_LAST);
    // Ready must have been seen on two edges so a held start picks up fresh data.
    assign w_accept = (r_state == IDLE) && sccb_start && r_readyAge;

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_qcnt     <= '0;
            r_bitIdx   <= '0;
            r_phase    <= '0;
            r_freeCnt  <= '0;
            r_frame    <= '0;
            r_readyAge <= 1'b0;
            r_ready    <= 1'b1;
            r_nack     <= 1'b0;
            r_sioc     <= 1'b1;
            r_siod     <= 1'b1;
            r_oe       <= 1'b1;
        end else begin
            r_qcnt <= w_tick ? '0 : r_qcnt + 1'b1;
            case (r_state)
                IDLE: begin
                    r_readyAge <= 1'b1;
                    if (w_accept) begin
                        r_frame    <= {DEVICE_ID, 1'b1, sccb_address, 1'b1, sccb_data, 1'b1};
                        r_nack     <= 1'b0;
                        r_qcnt     <= '0;
                        r_ready    <= 1'b0;
                        r_readyAge <= 1'b0;
                        r_siod     <= 1'b0;
                        r_oe       <= 1'b1;
                        r_state    <= START_A;
                    end
                end
                START_A: if (w_tick) begin
                    r_sioc  <= 1'b0;
                    r_state <= START_B;
                end
                START_B: if (w_tick) begin
                    r_bitIdx <= '0;
                    r_phase  <= '0;
                    r_siod   <= r_frame[26];
                    r_oe     <= 1'b1;
                    r_state  <= BIT;
                end
                BIT: if (w_tick) begin
                    r_phase <= r_phase + 1'b1;
                    case (r_phase)
                        2'd1: r_sioc <= 1'b1;
                        2'd2: if (!r_oe && siod_in) r_nack <= 1'b1;
                        2'd3: begin
                            r_sioc <= 1'b0;
                            if (r_bitIdx == 5'd26) begin
                                r_siod  <= 1'b0;
                                r_oe    <= 1'b1;
                                r_state <= STOP_A;
                            end else begin
                                r_bitIdx <= r_bitIdx + 5'd1;
                                r_frame  <= {r_frame[25:0], 1'b0};
                                r_siod   <= r_frame[25];
                                r_oe     <= ~isRelease(r_bitIdx + 5'd1);
                            end
                        end
                        default: ;
                    endcase
                end
                STOP_A: if (w_tick) begin
                    r_sioc  <= 1'b1;
                    r_state <= STOP_B;
                end
                STOP_B: if (w_tick) begin
                    r_siod    <= 1'b1;
                    r_freeCnt <= '0;
                    r_state   <= BUS_FREE;
                end
                BUS_FREE: if (w_tick) begin
                    if (r_freeCnt == F_LAST) begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_freeCnt <= r_freeCnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sccb_ready = r_ready;
    assign sccb_nack  = r_nack;
    assign sioc       = r_sioc;
    assign siod_out   = r_siod;
    assign siod_oe    = r_oe;
endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: a default-timing instance for handshake, nack and reset
// behaviour, and a fast-timing instance for random traffic under a bus monitor.
module tb_sccb_master;
    localparam logic [26:0] REL_PAT = 27'b000000001_000000001_000000001;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] mask;
        logic       expNack;
    } vec_t;

    typedef struct {
        logic        pS;
        logic        pL;
        logic        active;
        int          rises;
        int          hiLen;
        int          loLen;
        int          starts;
        int          stops;
        int          errs;
        logic [26:0] bits;
        logic [26:0] relBits;
    } mon_t;

    logic clk = 1'b0;
    logic rstA, rstB, startA, startB;
    logic [7:0] addrA, dataA, addrB, dataB;
    logic siodInA, siodInB;
    logic readyA, nackA, siocA, soA, oeA;
    logic readyB, nackB, siocB, soB, oeB;
    logic [3:0] maskA = 4'b0000;
    logic [1:0] relA = 2'd0;
    logic prevOeA = 1'b1;
    logic doneA, doneB;
    logic [26:0] expA, expB;
    logic [26:0] expQA[$];
    logic [26:0] expQB[$];
    mon_t monA = '{default: 0};
    mon_t monB = '{default: 0};
    int startsBefore;
    int runA = 0, runB = 0, lastLowA = 0, lastLowB = 0;
    int nCompared = 0, nMismatch = 0;
    int edges;
    vec_t vecs[3];

    always #20 clk = ~clk;

    assign siodInA = ~oeA & maskA[relA];
    assign siodInB = 1'b0;

    sccb_master dutA (
        .clk_25M(clk), .rst(rstA), .sccb_start(startA), .sccb_address(addrA),
        .sccb_data(dataA), .siod_in(siodInA), .sccb_ready(readyA), .sccb_nack(nackA),
        .sioc(siocA), .siod_out(soA), .siod_oe(oeA)
    );

    sccb_master #(.DEVICE_ID(8'h42), .QUARTER(4), .BUS_FREE_Q(2)) dutB (
        .clk_25M(clk), .rst(rstB), .sccb_start(startB), .sccb_address(addrB),
        .sccb_data(dataB), .siod_in(siodInB), .sccb_ready(readyB), .sccb_nack(nackB),
        .sioc(siocB), .siod_out(soB), .siod_oe(oeB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic mon_t monClear(input mon_t mi);
        mon_t m = mi;
        m.pS = 1'b1; m.pL = 1'b1; m.active = 1'b0;
        m.rises = 0; m.hiLen = 0; m.loLen = 0;
        return m;
    endfunction

    // One negedge sample of the bus: start/stop detection, pulse widths, frame capture.
    function automatic mon_t monStep(input mon_t mi, input logic sc, input logic so,
                                     input logic oe, input int q, output logic done);
        mon_t m = mi;
        logic line;
        int expLo;
        line = oe ? so : 1'b1;
        done = 1'b0;
        if (sc && m.pS && line != m.pL) begin
            if (!line) begin
                m.starts++; m.active = 1'b1; m.rises = 0;
            end else begin
                m.stops++;
                if (!m.active || m.rises != 28) m.errs++;
                m.active = 1'b0;
            end
        end
        if (sc && !m.pS) begin
            if (m.active) begin
                m.rises++;
                expLo = (m.rises == 1) ? 3 * q : (m.rises == 28) ? q : 2 * q;
                if (m.loLen != expLo) m.errs++;
                if (m.rises <= 27) begin
                    m.bits    = {m.bits[25:0], line};
                    m.relBits = {m.relBits[25:0], ~oe};
                end
                done = (m.rises == 27);
            end
            m.hiLen = 0;
        end else if (!sc && m.pS) begin
            if (m.active && m.rises >= 1 && m.hiLen != 2 * q) m.errs++;
            m.loLen = 0;
        end
        if (sc) m.hiLen++; else m.loLen++;
        m.pS = sc;
        m.pL = line;
        return m;
    endfunction

    // Bus monitors and scoreboards for both instances.
    always @(negedge clk) begin
        if (rstA) begin
            monA = monClear(monA);
            relA = 2'd0;
        end else begin
            startsBefore = monA.starts;
            monA = monStep(monA, siocA, soA, oeA, 63, doneA);
            if (monA.starts != startsBefore) relA = 2'd0;
            else if (oeA && !prevOeA) relA = relA + 2'd1;
            if (doneA) begin
                if (expQA.size() == 0) checkOutput("frameA_unexpected", 32'd1, 32'd0);
                else begin
                    expA = expQA.pop_front();
                    checkOutput("frameA_bits", 32'(monA.bits), 32'(expA));
                    checkOutput("frameA_release", 32'(monA.relBits), 32'(REL_PAT));
                end
            end
        end
        prevOeA = oeA;
        if (rstB) monB = monClear(monB);
        else begin
            monB = monStep(monB, siocB, soB, oeB, 4, doneB);
            if (doneB) begin
                if (expQB.size() == 0) checkOutput("frameB_unexpected", 32'd1, 32'd0);
                else begin
                    expB = expQB.pop_front();
                    checkOutput("frameB_bits", 32'(monB.bits), 32'(expB));
                    checkOutput("frameB_release", 32'(monB.relBits), 32'(REL_PAT));
                end
            end
        end
        if (!readyA) runA++;
        else if (runA != 0) begin lastLowA = runA; runA = 0; end
        if (!readyB) runB++;
        else if (runB != 0) begin lastLowB = runB; runB = 0; end
    end

    task automatic applyStimulus(input logic isB, input logic [7:0] a, input logic [7:0] d,
                                 input logic [3:0] mask, input logic push);
        if (isB) begin
            addrB = a; dataB = d;
            if (push) expQB.push_back({8'h42, 1'b1, a, 1'b1, d, 1'b1});
        end else begin
            addrA = a; dataA = d; maskA = mask;
            if (push) expQA.push_back({8'h42, 1'b1, a, 1'b1, d, 1'b1});
        end
    endtask

    task automatic waitAccept(input logic isB, output int n);
        n = 0;
        while ((isB ? readyB : readyA) && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitReady(input logic isB);
        int n = 0;
        while (!(isB ? readyB : readyA) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        #1;
    endtask

    initial begin
        vecs[0] = '{addr: 8'h12, data: 8'h80, mask: 4'b0000, expNack: 1'b0};
        vecs[1] = '{addr: 8'h11, data: 8'h01, mask: 4'b0010, expNack: 1'b1};
        vecs[2] = '{addr: 8'hA5, data: 8'h3C, mask: 4'b0100, expNack: 1'b1};

        rstA = 1'b1; rstB = 1'b1; startA = 1'b1; startB = 1'b0;
        addrA = 8'h00; dataA = 8'h00; addrB = 8'h00; dataB = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("resetA_pins", 32'({siocA, soA, oeA, readyA, nackA}), 32'b11110);
        checkOutput("resetB_pins", 32'({siocB, soB, oeB, readyB, nackB}), 32'b11110);

        // Held start: each new pair is loaded on the first cycle ready is high.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, vecs[i].addr, vecs[i].data, vecs[i].mask, 1'b1);
            if (i == 0) rstA = 1'b0;
            waitAccept(1'b0, edges);
            checkOutput($sformatf("acceptEdgeA_%0d", i), edges, 2);
            checkOutput($sformatf("nackClearA_%0d", i), 32'(nackA), 32'd0);
            waitReady(1'b0);
            checkOutput($sformatf("readyLowA_%0d", i), lastLowA, 7560);
            checkOutput($sformatf("nackA_%0d", i), 32'(nackA), 32'(vecs[i].expNack));
        end

        // Abort a transaction mid phase 2 with a one-cycle reset.
        applyStimulus(1'b0, 8'h5A, 8'hC3, 4'b0000, 1'b0);
        waitAccept(1'b0, edges);
        checkOutput("nackClearOnAccept", 32'(nackA), 32'd0);
        repeat (47 * 63) @(negedge clk);
        checkOutput("midBusyBeforeReset", 32'(readyA), 32'd0);
        @(posedge clk);
        #5 rstA = 1'b1;
        #1 checkOutput("midResetPins", 32'({siocA, soA, oeA, readyA, nackA}), 32'b11110);
        applyStimulus(1'b0, 8'h3B, 8'hE7, 4'b0000, 1'b1);
        @(posedge clk);
        #5 rstA = 1'b0;
        @(negedge clk);
        waitAccept(1'b0, edges);
        checkOutput("acceptEdgeAfterReset", edges, 2);
        waitReady(1'b0);
        checkOutput("readyLowAfterReset", lastLowA, 7560);
        checkOutput("nackAfterReset", 32'(nackA), 32'd0);
        startA = 1'b0;

        // Fast instance: random traffic, with start pulses while busy that must be ignored.
        @(negedge clk);
        rstB = 1'b0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'b0000, 1'b1);
            startB = 1'b1;
            waitAccept(1'b1, edges);
            checkOutput($sformatf("acceptEdgeB_%0d", k), edges, 2);
            startB = 1'b0;
            repeat (50) @(negedge clk);
            applyStimulus(1'b1, 8'hFF, 8'hFF, 4'b0000, 1'b0);
            startB = 1'b1;
            repeat (3) @(negedge clk);
            startB = 1'b0;
            waitReady(1'b1);
            checkOutput($sformatf("readyLowB_%0d", k), lastLowB, 456);
        end
        repeat (20) @(negedge clk);
        checkOutput("busStartsB", monB.starts, 20);
        checkOutput("busStopsB", monB.stops, 20);
        checkOutput("busViolationsB", monB.errs, 0);
        checkOutput("busViolationsA", monA.errs, 0);
        checkOutput("pendingFramesA", expQA.size(), 0);
        checkOutput("pendingFramesB", expQB.size(), 0);
        checkOutput("nackB", 32'(nackB), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end
endmodule
